ramp_scan_sequencer: RTL and testbench

Sequences ADC-lane deskew characterisation on the SNAP2 FMC path. It steps a lane's input-delay tap across a programmed range. At each tap it waits for the delay to settle, clears the shared ramp error counter, lets it accumulate for a fixed dwell, and reports the snapshot. It sits between the control-register bank and the delay/error-counter datapath, driving lane select, tap load and counter clear.

---
 rtl/ramp_scan_sequencer.sv | 269 ++++++++++++++++++++++++++
 tb/tb_ramp_scan_sequencer.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ramp_scan_sequencer.sv
// Deskew tap-scan sequencer: steps each enabled lane's delay tap across a range and reports error-counter snapshots.
// Defining RAMP_SCAN_BEST_TAP_EN adds per-lane tracking of the longest clean tap run (eye centre).
module ramp_scan_sequencer #(
    parameter int NLANES = 8,
    parameter int TAP_W  = 5,
    localparam int LW    = (NLANES > 1) ? $clog2(NLANES) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_i,
    input  logic              abort_i,
    input  logic [NLANES-1:0] lane_mask_i,
    input  logic [TAP_W-1:0]  tap_first_i,
    input  logic [TAP_W-1:0]  tap_last_i,
    input  logic [15:0]       settle_len_i,
    input  logic [31:0]       dwell_len_i,
    input  logic [63:0]       err_in_i,
    input  logic [63:0]       ok_in_i,
    input  logic              res_ready_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [LW-1:0]     lane_sel_o,
    output logic [TAP_W-1:0]  tap_val_o,
    output logic              tap_load_o,
    output logic              cnt_rst_o,
    output logic              res_valid_o,
    output logic [LW-1:0]     res_lane_o,
    output logic [TAP_W-1:0]  res_tap_o,
    output logic [63:0]       res_err_o,
    output logic [63:0]       res_ok_o,
    output logic              best_valid_o,
    output logic [LW-1:0]     best_lane_o,
    output logic [TAP_W-1:0]  best_tap_o,
    output logic [TAP_W:0]    best_len_o
);

    typedef enum logic [3:0] {
        IDLE, SELECT, LOAD, SETTLE, CLEAR, DWELL, CAPTURE, REPORT, DONE
    } state_t;

    state_t            state_q, state_d;
    logic              busy_q, busy_d;
    logic [NLANES-1:0] mask_q, mask_d;
    logic [TAP_W-1:0]  first_q, first_d, last_q, last_d, tap_q, tap_d;
    logic [15:0]       settle_q, settle_d;
    logic [31:0]       dwell_q, dwell_d, cnt_q, cnt_d;
    logic [LW-1:0]     lane_q, lane_d, next_lane;
    logic [LW:0]       idx_q, idx_d;
    logic [63:0]       err_q, err_d, ok_q, ok_d;
    logic              found;
    logic              xfer;
    logic              last_tap;

    assign xfer     = (state_q == REPORT) && res_ready_i;
    assign last_tap = !(tap_q < last_q);

    // Lowest enabled lane at or above the resume index; the downward loop lets the lowest match win.
    always_comb begin
        found     = 1'b0;
        next_lane = '0;
        for (int i = NLANES - 1; i >= 0; i--) begin
            if (mask_q[i] && (i >= int'(idx_q))) begin
                found     = 1'b1;
                next_lane = LW'(i);
            end
        end
    end

    always_comb begin
        // NOTE: every next-state signal takes its hold value first, so no branch can infer a latch.
        state_d  = state_q;
        mask_d   = mask_q;
        first_d  = first_q;
        last_d   = last_q;
        settle_d = settle_q;
        dwell_d  = dwell_q;
        idx_d    = idx_q;
        lane_d   = lane_q;
        tap_d    = tap_q;
        cnt_d    = cnt_q;
        err_d    = err_q;
        ok_d     = ok_q;
        unique case (state_q)
            IDLE: if (start_i && !abort_i) begin
                mask_d   = lane_mask_i;
                first_d  = tap_first_i;
                last_d   = tap_last_i;
                settle_d = settle_len_i;
                dwell_d  = dwell_len_i;
                idx_d    = '0;
                state_d  = SELECT;
            end
            SELECT: if (!found || (first_q > last_q)) begin
                state_d = DONE;
            end else begin
                lane_d  = next_lane;
                tap_d   = first_q;
                state_d = LOAD;
            end
            LOAD: if (settle_q == '0) begin
                state_d = CLEAR;
            end else begin
                cnt_d   = {16'd0, settle_q} - 32'd1;
                state_d = SETTLE;
            end
            SETTLE: if (cnt_q == '0) state_d = CLEAR; else cnt_d = cnt_q - 32'd1;
            CLEAR: if (dwell_q == '0) begin
                state_d = CAPTURE;
            end else begin
                cnt_d   = dwell_q - 32'd1;
                state_d = DWELL;
            end
            DWELL: if (cnt_q == '0) state_d = CAPTURE; else cnt_d = cnt_q - 32'd1;
            CAPTURE: begin
                err_d   = err_in_i;
                ok_d    = ok_in_i;
                state_d = REPORT;
            end
            REPORT: if (xfer) begin
                if (!last_tap) begin
                    tap_d   = tap_q + 1'b1;
                    state_d = LOAD;
                end else begin
                    idx_d   = {1'b0, lane_q} + 1'b1;
                    state_d = SELECT;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (abort_i && (state_q != IDLE)) state_d = IDLE;
        // Steering and result registers read zero whenever the sequencer is idle.
        if (state_d == IDLE) begin
            lane_d = '0;
            tap_d  = '0;
            cnt_d  = '0;
            err_d  = '0;
            ok_d   = '0;
        end
        busy_d = (state_q != IDLE) && !abort_i;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            busy_q   <= 1'b0;
            mask_q   <= '0;
            first_q  <= '0;
            last_q   <= '0;
            settle_q <= '0;
            dwell_q  <= '0;
            idx_q    <= '0;
            lane_q   <= '0;
            tap_q    <= '0;
            cnt_q    <= '0;
            err_q    <= '0;
            ok_q     <= '0;
        end else begin
            state_q  <= state_d;
            busy_q   <= busy_d;
            mask_q   <= mask_d;
            first_q  <= first_d;
            last_q   <= last_d;
            settle_q <= settle_d;
            dwell_q  <= dwell_d;
            idx_q    <= idx_d;
            lane_q   <= lane_d;
            tap_q    <= tap_d;
            cnt_q    <= cnt_d;
            err_q    <= err_d;
            ok_q     <= ok_d;
        end
    end

    assign busy_o      = busy_q;
    assign done_o      = (state_q == DONE);
    assign lane_sel_o  = lane_q;
    assign tap_val_o   = tap_q;
    assign tap_load_o  = (state_q == LOAD);
    assign cnt_rst_o   = (state_q == CLEAR);
    assign res_valid_o = (state_q == REPORT);
    assign res_lane_o  = lane_q;
    assign res_tap_o   = tap_q;
    assign res_err_o   = err_q;
    assign res_ok_o    = ok_q;

`ifdef RAMP_SCAN_BEST_TAP_EN
    logic [TAP_W:0]   run_len_q, run_len_d, top_len_q, top_len_d, cur_len, blen_q, blen_d;
    logic [TAP_W-1:0] run_start_q, run_start_d, top_start_q, top_start_d, cur_start, btap_q, btap_d;
    logic [LW-1:0]    blane_q, blane_d;
    logic             bvalid_q, bvalid_d;

    always_comb begin
        run_len_d   = run_len_q;
        run_start_d = run_start_q;
        top_len_d   = top_len_q;
        top_start_d = top_start_q;
        blane_d     = blane_q;
        btap_d      = btap_q;
        blen_d      = blen_q;
        bvalid_d    = 1'b0;
        cur_len     = '0;
        cur_start   = tap_q;
        if (err_q == '0) begin
            cur_len   = run_len_q + 1'b1;
            cur_start = (run_len_q == '0) ? tap_q : run_start_q;
        end
        if (state_q == SELECT) begin
            run_len_d   = '0;
            run_start_d = '0;
            top_len_d   = '0;
            top_start_d = '0;
        end else if (xfer) begin
            run_len_d   = cur_len;
            run_start_d = cur_start;
            // Strictly longer only, so a tie keeps the earlier run.
            if (cur_len > top_len_q) begin
                top_len_d   = cur_len;
                top_start_d = cur_start;
            end
            if (last_tap) begin
                bvalid_d = 1'b1;
                blane_d  = lane_q;
                blen_d   = top_len_d;
                btap_d   = (top_len_d == '0) ? '0 : top_start_d + TAP_W'((top_len_d - 1'b1) >> 1);
            end
        end
        if (state_d == IDLE) begin
            bvalid_d = 1'b0;
            blane_d  = '0;
            btap_d   = '0;
            blen_d   = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_len_q   <= '0;
            run_start_q <= '0;
            top_len_q   <= '0;
            top_start_q <= '0;
            blane_q     <= '0;
            btap_q      <= '0;
            blen_q      <= '0;
            bvalid_q    <= 1'b0;
        end else begin
            run_len_q   <= run_len_d;
            run_start_q <= run_start_d;
            top_len_q   <= top_len_d;
            top_start_q <= top_start_d;
            blane_q     <= blane_d;
            btap_q      <= btap_d;
            blen_q      <= blen_d;
            bvalid_q    <= bvalid_d;
        end
    end

    assign best_valid_o = bvalid_q;
    assign best_lane_o  = blane_q;
    assign best_tap_o   = btap_q;
    assign best_len_o   = blen_q;
`else
    assign best_valid_o = 1'b0;
    assign best_lane_o  = '0;
    assign best_tap_o   = '0;
    assign best_len_o   = '0;
`endif

endmodule

// File: tb/tb_ramp_scan_sequencer.sv
// Bench for ramp_scan_sequencer: table of scan configurations plus hand-written abort, reset and backpressure sequences.
// Results are matched against a queue of expected records built from a ramp-counter model of the datapath.
`timescale 1ns/1ps
module tb_ramp_scan_sequencer;
    localparam int NLANES = 8;
    localparam int TAP_W  = 5;
    localparam int LW     = 3;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0, abort = 1'b0, res_ready = 1'b1;
    logic [NLANES-1:0] lane_mask = '0;
    logic [TAP_W-1:0]  tap_first = '0, tap_last = '0;
    logic [15:0]       settle_len = '0;
    logic [31:0]       dwell_len = '0;
    logic [63:0]       err_cnt = '0, ok_cnt = '0;
    logic              busy, done, tap_load, cnt_rst, res_valid, best_valid;
    logic [LW-1:0]     lane_sel, res_lane, best_lane;
    logic [TAP_W-1:0]  tap_val, res_tap, best_tap;
    logic [TAP_W:0]    best_len;
    logic [63:0]       res_err, res_ok;

    always #5 clk = ~clk;

    ramp_scan_sequencer #(.NLANES(NLANES), .TAP_W(TAP_W)) dut (
        .clk(clk), .rst_n(rst_n), .start_i(start), .abort_i(abort),
        .lane_mask_i(lane_mask), .tap_first_i(tap_first), .tap_last_i(tap_last),
        .settle_len_i(settle_len), .dwell_len_i(dwell_len),
        .err_in_i(err_cnt), .ok_in_i(ok_cnt), .res_ready_i(res_ready),
        .busy_o(busy), .done_o(done), .lane_sel_o(lane_sel), .tap_val_o(tap_val),
        .tap_load_o(tap_load), .cnt_rst_o(cnt_rst), .res_valid_o(res_valid),
        .res_lane_o(res_lane), .res_tap_o(res_tap), .res_err_o(res_err), .res_ok_o(res_ok),
        .best_valid_o(best_valid), .best_lane_o(best_lane), .best_tap_o(best_tap), .best_len_o(best_len)
    );

    typedef struct {
        logic [LW-1:0]    lane;
        logic [TAP_W-1:0] tap;
        logic [63:0]      err;
        logic [63:0]      ok;
    } res_t;

    typedef struct {
        logic [7:0]  mask;
        int          first, last, settle, dwell;
        logic [31:0] err_taps;
        int          exp_n, exp_lanes, exp_blen, exp_btap;
    } vec_t;

    res_t        exp_q[$];
    res_t        e;
    int          vectors = 0, miscompares = 0;
    int          cyc = 0, xfer_cnt = 0, xfer_cyc = 0, done_cnt = 0, done_cyc = 0;
    int          tl_cnt = 0, tl_cyc = 0, tl_gap = 0, first_tl_cyc = -1;
    int          best_cnt = 0, b_lane = 0, b_tap = 0, b_len = 0;
    int          cur_dwell = 0;
    logic        best_seen = 1'b0;
    logic [31:0] err_taps = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Ramp counter model: cleared by cnt_rst, otherwise counts one error or one good word per cycle.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (cnt_rst) begin
            err_cnt <= '0;
            ok_cnt  <= '0;
        end else if (err_taps[tap_val]) begin
            err_cnt <= err_cnt + 64'd1;
        end else begin
            ok_cnt <= ok_cnt + 64'd1;
        end
    end

    always @(negedge clk) begin
        if (res_valid && res_ready) begin
            xfer_cnt++;
            xfer_cyc = cyc;
            check("err_plus_ok", res_err + res_ok, 64'(cur_dwell));
            check("result_expected", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("res_lane", 64'(res_lane), 64'(e.lane));
                check("res_tap", 64'(res_tap), 64'(e.tap));
                check("res_err", res_err, e.err);
                check("res_ok", res_ok, e.ok);
            end
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (tap_load) begin
            tl_cnt++;
            tl_gap = cyc - tl_cyc;
            tl_cyc = cyc;
            if (first_tl_cyc < 0) first_tl_cyc = cyc;
        end
        if (best_valid) begin
            best_cnt++;
            b_lane = int'(best_lane);
            b_tap  = int'(best_tap);
            b_len  = int'(best_len);
        end
        if (best_valid || (best_lane != '0) || (best_tap != '0) || (best_len != '0)) best_seen = 1'b1;
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step(1);
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string tag);
        int d0, k;
        d0 = done_cnt;
        k  = 0;
        while (done_cnt == d0 && k < budget) begin
            step(1);
            k++;
        end
        check({tag, "_done_pulse"}, 64'(done_cnt - d0), 64'd1);
        if (done_cnt == d0) begin
            abort = 1'b1;
            step(1);
            abort = 1'b0;
        end
        step(1);
        check({tag, "_idle_after"}, 64'(busy), 64'd0);
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        res_t r;
        int   n0, b0;
        err_taps  = v.err_taps;
        cur_dwell = v.dwell;
        for (int l = 0; l < NLANES; l++) begin
            if (v.mask[l]) begin
                for (int t = v.first; t <= v.last; t++) begin
                    r.lane = LW'(l);
                    r.tap  = TAP_W'(t);
                    r.err  = v.err_taps[t] ? 64'(v.dwell) : 64'd0;
                    r.ok   = v.err_taps[t] ? 64'd0 : 64'(v.dwell);
                    exp_q.push_back(r);
                end
            end
        end
        n0 = xfer_cnt;
        b0 = best_cnt;
        lane_mask  = v.mask;
        tap_first  = TAP_W'(v.first);
        tap_last   = TAP_W'(v.last);
        settle_len = 16'(v.settle);
        dwell_len  = 32'(v.dwell);
        pulse_start();
        wait_done(5000, tag);
        check({tag, "_results"}, 64'(xfer_cnt - n0), 64'(v.exp_n));
        check({tag, "_queue_left"}, 64'(exp_q.size()), 64'd0);
        if (v.exp_n >= 2) check({tag, "_tap_period"}, 64'(tl_gap), 64'(4 + v.settle + v.dwell));
`ifdef RAMP_SCAN_BEST_TAP_EN
        check({tag, "_best_pulses"}, 64'(best_cnt - b0), 64'(v.exp_lanes));
        if (v.exp_lanes > 0) begin
            check({tag, "_best_len"}, 64'(b_len), 64'(v.exp_blen));
            check({tag, "_best_tap"}, 64'(b_tap), 64'(v.exp_btap));
        end
`else
        check({tag, "_best_tied_low"}, 64'(best_seen), 64'd0);
`endif
        exp_q.delete();
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[7];
        res_t r;
        int   s, n0, tl0, d0, k, bad;
        logic [63:0] snap_err, snap_ok;
        logic [TAP_W-1:0] snap_tap;

        //               mask   first last settle dwell err_taps   n  lanes blen btap
        vecs[0] = '{8'h82,  0,   2,    2,    20, 32'h0000_0000, 6, 2, 3, 1};
        vecs[1] = '{8'h00,  0,   3,    0,     5, 32'h0000_0000, 0, 0, 0, 0};
        vecs[2] = '{8'h01,  5,   2,    1,     5, 32'h0000_0000, 0, 0, 0, 0};
        vecs[3] = '{8'h10, 30,  31,    0,     3, 32'h0000_0000, 2, 1, 2, 30};
        vecs[4] = '{8'h01,  0,   9,    1,     8, 32'h0000_0083, 10, 1, 5, 4};
        vecs[5] = '{8'h24,  4,   6,    3,     0, 32'h0000_0020, 6, 2, 3, 5};
        vecs[6] = '{8'h08,  0,   6,    0,     2, 32'h0000_0008, 7, 1, 3, 1};

        step(3);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_tap_load", 64'(tap_load), 64'd0);
        check("rst_cnt_rst", 64'(cnt_rst), 64'd0);
        check("rst_res_valid", 64'(res_valid), 64'd0);
        check("rst_lane_tap", 64'({lane_sel, tap_val}), 64'd0);
        check("rst_res_data", res_err | res_ok, 64'd0);
        check("rst_best", 64'({best_valid, best_len, best_tap}), 64'd0);
        rst_n = 1'b1;
        step(2);

        // Single tap: load strobe two cycles after start, done after the SELECT that follows the transfer.
        err_taps  = '0;
        cur_dwell = 100;
        r = '{3'd0, 5'd3, 64'd0, 64'd100};
        exp_q.push_back(r);
        lane_mask = 8'h01; tap_first = 5'd3; tap_last = 5'd3; settle_len = 16'd4; dwell_len = 32'd100;
        n0 = xfer_cnt; tl0 = tl_cnt; first_tl_cyc = -1;
        s = cyc;
        pulse_start();
        check("single_select_no_load", 64'(tap_load), 64'd0);
        step(1);
        check("single_load_c2", 64'(tap_load), 64'd1);
        check("single_busy_c2", 64'(busy), 64'd1);
        check("single_tap_val", 64'(tap_val), 64'd3);
        pulse_start();
        wait_done(1000, "single");
        check("single_load_cycle", 64'(first_tl_cyc - s), 64'd2);
        check("single_done_after_xfer", 64'(done_cyc - xfer_cyc), 64'd2);
        check("single_results", 64'(xfer_cnt - n0), 64'd1);
        check("single_loads", 64'(tl_cnt - tl0), 64'd1);

        for (int i = 0; i < 7; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        // Backpressure on the second result: outputs frozen and no new tap load while stalled.
        err_taps  = '0;
        cur_dwell = 10;
        for (int t = 0; t < 3; t++) begin
            r = '{3'd0, TAP_W'(t), 64'd0, 64'd10};
            exp_q.push_back(r);
        end
        lane_mask = 8'h01; tap_first = 5'd0; tap_last = 5'd2; settle_len = 16'd1; dwell_len = 32'd10;
        n0 = xfer_cnt;
        pulse_start();
        k = 0;
        while (xfer_cnt == n0 && k < 200) begin step(1); k++; end
        res_ready = 1'b0;
        k = 0;
        while (!res_valid && k < 200) begin step(1); k++; end
        check("bp_valid_seen", 64'(res_valid), 64'd1);
        snap_err = res_err; snap_ok = res_ok; snap_tap = res_tap;
        tl0 = tl_cnt;
        bad = 0;
        for (int c = 0; c < 20; c++) begin
            step(1);
            if (!res_valid || res_err !== snap_err || res_ok !== snap_ok || res_tap !== snap_tap) bad++;
        end
        check("bp_held_stable", 64'(bad), 64'd0);
        check("bp_no_tap_load", 64'(tl_cnt - tl0), 64'd0);
        check("bp_held_tap", 64'(snap_tap), 64'd1);
        res_ready = 1'b1;
        wait_done(500, "bp");
        check("bp_results", 64'(xfer_cnt - n0), 64'd3);
        exp_q.delete();

        // Abort in DWELL: idle on the next cycle, nothing reported, no done.
        lane_mask = 8'h01; tap_first = 5'd4; tap_last = 5'd4; settle_len = 16'd0; dwell_len = 32'd200;
        n0 = xfer_cnt; d0 = done_cnt;
        pulse_start();
        k = 0;
        while (!cnt_rst && k < 50) begin step(1); k++; end
        step(5);
        check("abort_pre_busy", 64'(busy), 64'd1);
        abort = 1'b1;
        step(1);
        abort = 1'b0;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_outputs", 64'({res_valid, tap_load, cnt_rst, lane_sel, tap_val}), 64'd0);
        tl0 = tl_cnt;
        step(250);
        check("abort_no_done", 64'(done_cnt - d0), 64'd0);
        check("abort_no_result", 64'(xfer_cnt - n0), 64'd0);
        check("abort_no_reload", 64'(tl_cnt - tl0), 64'd0);

        // Abort and start together while idle: the scan never begins.
        start = 1'b1; abort = 1'b1;
        step(1);
        start = 1'b0; abort = 1'b0;
        step(3);
        check("abort_start_busy", 64'(busy), 64'd0);
        check("abort_start_no_load", 64'(tl_cnt - tl0), 64'd0);

        // Reset asserted mid-REPORT with a transfer pending: outputs clear before the next edge.
        res_ready = 1'b0;
        lane_mask = 8'h04; tap_first = 5'd2; tap_last = 5'd2; settle_len = 16'd0; dwell_len = 32'd6;
        n0 = xfer_cnt; d0 = done_cnt;
        pulse_start();
        k = 0;
        while (!res_valid && k < 100) begin step(1); k++; end
        check("rstrep_valid_seen", 64'(res_valid), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("rstrep_valid", 64'(res_valid), 64'd0);
        check("rstrep_data", res_err | res_ok, 64'd0);
        check("rstrep_busy_done", 64'({busy, done}), 64'd0);
        check("rstrep_lane_tap", 64'({lane_sel, tap_val, res_lane, res_tap}), 64'd0);
        step(1);
        rst_n = 1'b1;
        res_ready = 1'b1;
        step(5);
        check("rstrep_no_result", 64'(xfer_cnt - n0), 64'd0);
        check("rstrep_no_done", 64'(done_cnt - d0), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
